dm_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-ported data memory `dm`. It accepts load/store commands from port 0 (CPU MEM stage) and port 1 (debug/loader master), and grants one access at a time. For the granted access it drives the `dm` control and data signals for exactly one clock, then captures the load data and returns it with an acknowledge. Misaligned, out-of-range and illegal-type commands are rejected without touching memory.

---
 rtl/dm_arbiter.sv | 138 +++++++++++++
 tb/tb_dm_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for the single-ported data memory dm.
// One granted access per IDLE -> ACCESS -> RESP round; illegal commands never strobe dm.
module dm_arbiter #(
    parameter int unsigned DEPTH      = 32768,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [2:0]  p0_dmtype,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [2:0]  p1_dmtype,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [31:0] p1_rdata,
    output logic        MemWrite,
    output logic        MemRead,
    output logic [2:0]  DMType,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    input  logic [31:0] Read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      r_state;
    logic        r_last;
    logic        r_port;
    logic        r_we;
    logic        r_err;

    logic        w_p1_wins;
    logic        w_we;
    logic [2:0]  w_type;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [32:0] w_size_m1;
    logic [32:0] w_last_byte;
    logic        w_misalign;
    logic        w_err;
    logic [31:0] w_capture;

    always_comb begin
        if (p0_req && p1_req) begin
            w_p1_wins = FIXED_PRIO ? 1'b0 : ~r_last;
        end else begin
            w_p1_wins = p1_req;
        end
        w_we    = w_p1_wins ? p1_we     : p0_we;
        w_type  = w_p1_wins ? p1_dmtype : p0_dmtype;
        w_addr  = w_p1_wins ? p1_addr   : p0_addr;
        w_wdata = w_p1_wins ? p1_wdata  : p0_wdata;

        case (w_type[1:0])
            2'b01:   w_size_m1 = 33'd1;
            2'b10:   w_size_m1 = 33'd3;
            default: w_size_m1 = 33'd0;
        endcase
        w_misalign = ((w_type[1:0] == 2'b01) && w_addr[0]) ||
                     ((w_type[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
        // 33-bit sum so an address near 2^32 cannot wrap back into range
        w_last_byte = {1'b0, w_addr} + w_size_m1;
        w_err = (w_type[1:0] == 2'b11) || (w_we && w_type[2]) || w_misalign ||
                (w_last_byte > (33'(DEPTH) - 33'd1));

        w_capture = (r_we || r_err) ? '0 : Read_data;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_port     <= 1'b0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_err     <= 1'b0;
            p1_err     <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
            MemWrite   <= 1'b0;
            MemRead    <= 1'b0;
            DMType     <= '0;
            Address    <= '0;
            Write_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        r_port     <= w_p1_wins;
                        r_last     <= w_p1_wins;
                        r_we       <= w_we;
                        r_err      <= w_err;
                        DMType     <= w_type;
                        Address    <= w_addr;
                        Write_data <= w_wdata;
                        MemWrite   <= w_we & ~w_err;
                        MemRead    <= ~w_we & ~w_err;
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    MemWrite <= 1'b0;
                    MemRead  <= 1'b0;
                    if (r_port) begin
                        p1_rdata <= w_capture;
                        p1_ack   <= 1'b1;
                        p1_err   <= r_err;
                    end else begin
                        p0_rdata <= w_capture;
                        p0_ack   <= 1'b1;
                        p0_err   <= r_err;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    p0_ack  <= 1'b0;
                    p1_ack  <= 1'b0;
                    p0_err  <= 1'b0;
                    p1_err  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomised bench for dm_arbiter: a transaction-level reference model predicts every
// output each cycle; directed scenarios add literal expectations on top.
module tb_dm_arbiter;

    localparam int unsigned DEPTH = 32768;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        p0_req, p1_req, p0_we, p1_we;
    logic [2:0]  p0_dmtype, p1_dmtype;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic        p0_ack, p1_ack, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        MemWrite, MemRead;
    logic [2:0]  DMType;
    logic [31:0] Address, Write_data, Read_data;

    logic        fp_p0_req, fp_p1_req;
    logic        fp_p0_ack, fp_p1_ack, fp_p0_err, fp_p1_err;
    logic [31:0] fp_p0_rdata, fp_p1_rdata;
    logic        fp_MemWrite, fp_MemRead;
    logic [2:0]  fp_DMType;
    logic [31:0] fp_Address, fp_Write_data, fp_Read_data;

    dm_arbiter #(.DEPTH(DEPTH), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rstn(rstn),
        .p0_req(p0_req), .p0_we(p0_we), .p0_dmtype(p0_dmtype), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_dmtype(p1_dmtype), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .MemWrite(MemWrite), .MemRead(MemRead), .DMType(DMType), .Address(Address),
        .Write_data(Write_data), .Read_data(Read_data)
    );

    dm_arbiter #(.DEPTH(DEPTH), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rstn(rstn),
        .p0_req(fp_p0_req), .p0_we(1'b0), .p0_dmtype(3'b110), .p0_addr(32'h20),
        .p0_wdata(32'h0), .p0_ack(fp_p0_ack), .p0_err(fp_p0_err), .p0_rdata(fp_p0_rdata),
        .p1_req(fp_p1_req), .p1_we(1'b0), .p1_dmtype(3'b110), .p1_addr(32'h40),
        .p1_wdata(32'h0), .p1_ack(fp_p1_ack), .p1_err(fp_p1_err), .p1_rdata(fp_p1_rdata),
        .MemWrite(fp_MemWrite), .MemRead(fp_MemRead), .DMType(fp_DMType), .Address(fp_Address),
        .Write_data(fp_Write_data), .Read_data(fp_Read_data)
    );

    assign fp_Read_data = 32'hCAFE0000 | {16'h0, fp_Address[15:0]};

    // dm behaviour: combinational read with extension, store commits on negedge
    logic [7:0]  dmem [DEPTH];
    logic [14:0] dm_idx;
    logic [31:0] dm_word;
    initial for (int i = 0; i < int'(DEPTH); i++) dmem[i] = 8'h00;

    always_comb begin
        dm_idx  = Address[14:0];
        dm_word = {dmem[dm_idx + 15'd3], dmem[dm_idx + 15'd2], dmem[dm_idx + 15'd1], dmem[dm_idx]};
        case (DMType)
            3'b000:  Read_data = {{24{dm_word[7]}}, dm_word[7:0]};
            3'b001:  Read_data = {{16{dm_word[15]}}, dm_word[15:0]};
            3'b100:  Read_data = {24'h0, dm_word[7:0]};
            3'b101:  Read_data = {16'h0, dm_word[15:0]};
            default: Read_data = dm_word;
        endcase
    end

    always @(negedge clk) begin
        if (MemWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (i < (1 << DMType[1:0])) dmem[15'(Address + 32'(i))] = Write_data[8*i +: 8];
            end
        end
    end

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errs++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, want, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [7:0] ref_mem [int unsigned];

    function automatic int unsigned size_of(input logic [2:0] t);
        return 32'd1 << t[1:0];
    endfunction

    function automatic bit exp_err(input bit we, input logic [2:0] t, input logic [31:0] a);
        longint unsigned sz;
        if (t[1:0] == 2'b11) return 1'b1;
        if (we && t[2]) return 1'b1;
        sz = 64'(size_of(t));
        if ((64'(a) % sz) != 64'd0) return 1'b1;
        return (64'(a) + sz) > 64'(DEPTH);
    endfunction

    function automatic void mem_store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        for (int unsigned i = 0; i < size_of(t); i++) ref_mem[a + i] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] mem_load(input logic [2:0] t, input logic [31:0] a);
        logic [31:0] v = '0;
        int unsigned sz = size_of(t);
        for (int unsigned i = 0; i < sz; i++)
            if (ref_mem.exists(a + i)) v = v | (32'(ref_mem[a + i]) << (8 * i));
        if (!t[2] && sz < 4 && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
        return v;
    endfunction

    int          m_busy = 0;
    bit          m_last = 1'b1, m_port, m_we, m_err;
    logic [2:0]  m_t;
    logic [31:0] m_a, m_d, m_rd;
    bit   [1:0]  e_ack = '0, e_err = '0;
    logic [31:0] e_rd0 = '0, e_rd1 = '0;
    bit          e_mw = 1'b0, e_mr = 1'b0, e_cmd = 1'b1;
    logic [2:0]  e_t = '0;
    logic [31:0] e_a = '0, e_d = '0;

    always @(posedge clk) begin
        if (!rstn) begin
            m_busy = 0; m_last = 1'b1; e_ack = '0; e_err = '0; e_rd0 = '0; e_rd1 = '0;
            e_mw = 1'b0; e_mr = 1'b0; e_cmd = 1'b1; e_t = '0; e_a = '0; e_d = '0;
        end else if (m_busy == 0) begin
            if (p0_req || p1_req) begin
                m_port = (p0_req && p1_req) ? !m_last : p1_req;
                m_last = m_port;
                m_we = m_port ? p1_we : p0_we;
                m_t  = m_port ? p1_dmtype : p0_dmtype;
                m_a  = m_port ? p1_addr : p0_addr;
                m_d  = m_port ? p1_wdata : p0_wdata;
                m_err = exp_err(m_we, m_t, m_a);
                if (m_we && !m_err) mem_store(m_t, m_a, m_d);
                m_rd = (m_we || m_err) ? 32'h0 : mem_load(m_t, m_a);
                e_mw = m_we && !m_err; e_mr = !m_we && !m_err;
                e_t = m_t; e_a = m_a; e_d = m_d; e_cmd = 1'b1;
                m_busy = 2;
            end
        end else if (m_busy == 2) begin
            e_mw = 1'b0; e_mr = 1'b0; e_cmd = 1'b0;
            e_ack[m_port] = 1'b1; e_err[m_port] = m_err;
            if (m_port) e_rd1 = m_rd; else e_rd0 = m_rd;
            m_busy = 1;
        end else begin
            e_ack = '0; e_err = '0;
            m_busy = 0;
        end
    end

    always @(negedge clk) begin
        chk("p0_ack", 32'(p0_ack), 32'(e_ack[0]));
        chk("p1_ack", 32'(p1_ack), 32'(e_ack[1]));
        chk("MemWrite", 32'(MemWrite), 32'(e_mw));
        chk("MemRead", 32'(MemRead), 32'(e_mr));
        chk("p0_rdata", p0_rdata, e_rd0);
        chk("p1_rdata", p1_rdata, e_rd1);
        if (e_ack[0]) chk("p0_err", 32'(p0_err), 32'(e_err[0]));
        if (e_ack[1]) chk("p1_err", 32'(p1_err), 32'(e_err[1]));
        if (e_cmd) begin
            chk("DMType", 32'(DMType), 32'(e_t));
            chk("Address", Address, e_a);
            chk("Write_data", Write_data, e_d);
        end
    end

    // observation counters used by the directed scenarios
    int mw_cnt = 0, mr_cnt = 0, cyc = 0;
    int ack_port_q[$];
    int ack_cyc_q[$];
    always @(negedge clk) begin
        cyc++;
        if (MemWrite) mw_cnt++;
        if (MemRead) mr_cnt++;
        if (p0_ack) begin ack_port_q.push_back(0); ack_cyc_q.push_back(cyc); end
        if (p1_ack) begin ack_port_q.push_back(1); ack_cyc_q.push_back(cyc); end
    end

    // ---------------- drivers ----------------
    task automatic issue(input bit p, input bit we, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output bit er, output int lat);
        bit got = 1'b0;
        @(posedge clk); #1;
        if (!p) begin p0_req = 1'b1; p0_we = we; p0_dmtype = t; p0_addr = a; p0_wdata = d; end
        else    begin p1_req = 1'b1; p1_we = we; p1_dmtype = t; p1_addr = a; p1_wdata = d; end
        lat = 0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            got = p ? p1_ack : p0_ack;
        end
        if (!got) begin
            n_checks++;
            n_errs++;
            $display("FAIL ack_timeout port %0d: no ack after %0d cycles, ack required", p, lat);
        end
        rd = p ? p1_rdata : p0_rdata;
        er = p ? p1_err : p0_err;
    endtask

    task automatic drop_req(input bit p);
        @(posedge clk); #1;
        if (!p) p0_req = 1'b0; else p1_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
    endtask

    task automatic rand_port(input bit p, input int n);
        logic [31:0] rd, a;
        bit er;
        int lat;
        int unsigned gap, r;
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                drop_req(p);
                repeat (gap) @(posedge clk);
            end
            r = $urandom_range(0, 9);
            if (r < 7)      a = 32'($urandom_range(0, 31));
            else if (r < 9) a = 32'(DEPTH - 8 + $urandom_range(0, 7));
            else            a = $urandom;
            issue(p, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, rd, er, lat);
        end
        drop_req(p);
    endtask

    initial begin
        #300000;
        n_errs++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, rd0, rd1;
        bit er, er0, er1;
        int lat, lat0, lat1, c0, c1;
        int exp_ord[4] = '{0, 1, 0, 1};

        rstn = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_dmtype = '0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_dmtype = '0; p1_addr = '0; p1_wdata = '0;
        fp_p0_req = 1'b0; fp_p1_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_p0_rdata", p0_rdata, 32'h0);
        chk("rst_MemWrite", 32'(MemWrite), 32'h0);
        chk("rst_Address", Address, 32'h0);
        chk("rst_p1_ack", 32'(p1_ack), 32'h0);
        @(posedge clk); #1 rstn = 1'b1;

        // word store then load on port 0
        mw_cnt = 0;
        issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, rd, er, lat);
        chk("st_latency", 32'(lat), 32'd3);
        chk("st_err", 32'(er), 32'h0);
        chk("st_memwrite_cycles", 32'(mw_cnt), 32'd1);
        mr_cnt = 0;
        issue(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, rd, er, lat);
        chk("ld_word", rd, 32'hDEADBEEF);
        chk("ld_latency", 32'(lat), 32'd3);
        chk("ld_memread_cycles", 32'(mr_cnt), 32'd1);

        // half stores / signed and unsigned loads
        issue(1'b0, 1'b1, 3'b001, 32'h10, 32'h00008001, rd, er, lat);
        issue(1'b0, 1'b0, 3'b001, 32'h10, 32'h0, rd, er, lat);
        chk("ld_half_signed", rd, 32'hFFFF8001);
        issue(1'b0, 1'b0, 3'b101, 32'h10, 32'h0, rd, er, lat);
        chk("ld_half_unsigned", rd, 32'h00008001);

        // rejected commands
        mr_cnt = 0;
        issue(1'b0, 1'b0, 3'b010, 32'h102, 32'h0, rd, er, lat);
        chk("err_misaligned", 32'(er), 32'h1);
        chk("err_misaligned_rdata", rd, 32'h0);
        chk("err_misaligned_memread", 32'(mr_cnt), 32'h0);
        mw_cnt = 0;
        issue(1'b0, 1'b1, 3'b100, 32'h20, 32'h55, rd, er, lat);
        chk("err_store_unsigned", 32'(er), 32'h1);
        chk("err_store_memwrite", 32'(mw_cnt), 32'h0);
        issue(1'b0, 1'b0, 3'b010, 32'(DEPTH - 2), 32'h0, rd, er, lat);
        chk("err_word_depth_m2", 32'(er), 32'h1);
        issue(1'b0, 1'b1, 3'b010, 32'(DEPTH - 4), 32'hA5A55A5A, rd, er, lat);
        chk("ok_store_depth_m4", 32'(er), 32'h0);
        issue(1'b0, 1'b0, 3'b010, 32'(DEPTH - 4), 32'h0, rd, er, lat);
        chk("ok_load_depth_m4", rd, 32'hA5A55A5A);
        chk("ok_load_depth_m4_err", 32'(er), 32'h0);
        drop_req(1'b0);

        // simultaneous requests, round robin
        do_reset();
        ack_port_q.delete();
        ack_cyc_q.delete();
        fork
            begin
                issue(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, rd0, er0, lat0);
                issue(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, rd0, er0, lat0);
                drop_req(1'b0);
            end
            begin
                issue(1'b1, 1'b0, 3'b101, 32'h10, 32'h0, rd1, er1, lat1);
                issue(1'b1, 1'b0, 3'b101, 32'h10, 32'h0, rd1, er1, lat1);
                drop_req(1'b1);
            end
        join
        chk("rr_p0_rdata", rd0, 32'hDEADBEEF);
        chk("rr_p1_rdata", rd1, 32'h00008001);
        chk("rr_ack_count", 32'(ack_port_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ack_port_q.size()) begin
                chk("rr_grant_order", 32'(ack_port_q[i]), 32'(exp_ord[i]));
                if (i > 0) chk("rr_ack_spacing", 32'(ack_cyc_q[i] - ack_cyc_q[i-1]), 32'd3);
            end
        end

        // reset during ACCESS abandons the access; the committed store survives
        @(posedge clk); #1;
        p0_req = 1'b1; p0_we = 1'b1; p0_dmtype = 3'b010; p0_addr = 32'h200; p0_wdata = 32'h12345678;
        c0 = 0;
        do begin
            @(negedge clk);
            c0++;
        end while (!MemWrite && c0 < 10);
        chk("rst_mid_reached_access", 32'(MemWrite), 32'h1);
        rstn = 1'b0;
        p0_req = 1'b0;
        @(negedge clk);
        chk("rst_mid_ack", 32'(p0_ack), 32'h0);
        chk("rst_mid_MemWrite", 32'(MemWrite), 32'h0);
        chk("rst_mid_Address", Address, 32'h0);
        chk("rst_mid_Write_data", Write_data, 32'h0);
        chk("rst_mid_p0_rdata", p0_rdata, 32'h0);
        @(posedge clk); #1 rstn = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_no_late_ack", 32'(p0_ack), 32'h0);
        end
        issue(1'b0, 1'b0, 3'b010, 32'h200, 32'h0, rd, er, lat);
        chk("rst_mid_reissue", rd, 32'h12345678);
        drop_req(1'b0);

        // random traffic from both ports
        fork
            rand_port(1'b0, 40);
            rand_port(1'b1, 40);
        join
        repeat (4) @(posedge clk);

        // fixed priority instance: port 0 wins every arbitration
        @(posedge clk); #1;
        fp_p0_req = 1'b1;
        fp_p1_req = 1'b1;
        c0 = 0;
        c1 = 0;
        repeat (30) begin
            @(negedge clk);
            if (fp_p0_ack) begin
                c0++;
                chk("fp_p0_rdata", fp_p0_rdata, 32'hCAFE0020);
                chk("fp_p0_err", 32'(fp_p0_err), 32'h0);
            end
            if (fp_p1_ack) c1++;
        end
        chk("fp_p0_ack_count", 32'(c0), 32'd10);
        chk("fp_p1_ack_count", 32'(c1), 32'd0);
        @(posedge clk); #1;
        fp_p0_req = 1'b0;
        fp_p1_req = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
